// File: rtl/axi_mem_responder_if.sv
// Bus bundle for axi_mem_responder: AXI4 slave channels plus the simple memory request port.
// slave = responder view, master = external AXI master / memory target view.
interface axi_mem_responder_if;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awlock;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic [3:0]  s_axi_awqos;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arcache;
    logic [2:0]  s_axi_arprot;
    logic [3:0]  s_axi_arqos;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
               s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
               s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
               s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid, s_axi_rready,
               mem_rdata, mem_ready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
               mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
               s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
               s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
               s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid, s_axi_rready,
               mem_rdata, mem_ready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
               mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave turning each data beat into one simple-memory request, one transaction at a time.
// Optional AXI_BURST_EN: multi-beat bursts up to MAX_LEN; otherwise any len>0 is answered SLVERR.
module axi_mem_responder #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic clk,
    input  logic rst,
    axi_mem_responder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    state_t      state;
    logic        acc_en;
    logic        wr_prio;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  beat;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;
    logic        wl_err;

    logic        wready_q, bvalid_q, rvalid_q, rlast_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic        mem_valid_q, mem_instr_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

    logic        last_beat, conflict, aw_hs, ar_hs, rd_err_new, wr_err_new;
    logic [31:0] next_addr;
    logic        unused_sigs;

    function automatic logic req_err(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
        logic e;
        e = (b == 2'b11) || (b == 2'b10) || (s > 3'd2);
`ifdef AXI_BURST_EN
        e = e || (32'(l) > MAX_LEN);
`else
        e = e || (l != 8'd0);
`endif
        return e;
    endfunction

    // Readies come from a registered idle flag; the losing channel of a conflict is
    // masked combinationally so only one address handshake can happen per cycle.
    assign bus.s_axi_awready = acc_en & ~(bus.s_axi_arvalid & ~wr_prio);
    assign bus.s_axi_arready = acc_en & ~(bus.s_axi_awvalid & wr_prio);

    always_comb begin
        last_beat  = (beat == len);
        conflict   = bus.s_axi_awvalid & bus.s_axi_arvalid;
        aw_hs      = bus.s_axi_awvalid & bus.s_axi_awready;
        ar_hs      = bus.s_axi_arvalid & bus.s_axi_arready;
        rd_err_new = req_err(bus.s_axi_arburst, bus.s_axi_arsize, bus.s_axi_arlen);
        wr_err_new = req_err(bus.s_axi_awburst, bus.s_axi_awsize, bus.s_axi_awlen);
        next_addr  = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            acc_en      <= 1'b0;
            wr_prio     <= 1'b1;
            addr        <= '0;
            len         <= '0;
            beat        <= '0;
            size        <= '0;
            burst       <= '0;
            err         <= 1'b0;
            wl_err      <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            mem_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    acc_en <= 1'b1;
                    if (acc_en && conflict) wr_prio <= ~wr_prio;
                    if (aw_hs) begin
                        acc_en      <= 1'b0;
                        addr        <= bus.s_axi_awaddr;
                        len         <= bus.s_axi_awlen;
                        size        <= bus.s_axi_awsize;
                        burst       <= bus.s_axi_awburst;
                        mem_instr_q <= bus.s_axi_awprot[2];
                        err         <= wr_err_new;
                        wl_err      <= 1'b0;
                        beat        <= '0;
                        wready_q    <= 1'b1;
                        state       <= WR_DATA;
                    end else if (ar_hs) begin
                        acc_en      <= 1'b0;
                        addr        <= bus.s_axi_araddr;
                        len         <= bus.s_axi_arlen;
                        size        <= bus.s_axi_arsize;
                        burst       <= bus.s_axi_arburst;
                        mem_instr_q <= bus.s_axi_arprot[2];
                        err         <= rd_err_new;
                        beat        <= '0;
                        mem_valid_q <= ~rd_err_new;
                        mem_addr_q  <= bus.s_axi_araddr - ADDR_BASE;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                        state       <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (err) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= '0;
                        rresp_q  <= RESP_SLVERR;
                        rlast_q  <= last_beat;
                        state    <= RD_RESP;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_ready) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= bus.mem_rdata;
                        rresp_q  <= RESP_OKAY;
                        rlast_q  <= last_beat;
                        state    <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (bus.s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            beat        <= beat + 8'd1;
                            addr        <= next_addr;
                            mem_addr_q  <= next_addr - ADDR_BASE;
                            mem_valid_q <= ~err;
                            state       <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (bus.s_axi_wvalid && wready_q) begin
                        wready_q    <= 1'b0;
                        mem_wdata_q <= bus.s_axi_wdata;
                        mem_wstrb_q <= bus.s_axi_wstrb;
                        mem_addr_q  <= addr - ADDR_BASE;
                        mem_valid_q <= ~err;
                        if (bus.s_axi_wlast != last_beat) wl_err <= 1'b1;
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    // mem_ready is only honoured after the request pulse has dropped.
                    if (!mem_valid_q && (err || bus.mem_ready)) begin
                        if (last_beat) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err || wl_err) ? RESP_SLVERR : RESP_OKAY;
                            state    <= WR_RESP;
                        end else begin
                            beat     <= beat + 8'd1;
                            addr     <= next_addr;
                            wready_q <= 1'b1;
                            state    <= WR_DATA;
                        end
                    end
                end
                WR_RESP: begin
                    if (bus.s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_axi_wready = wready_q;
    assign bus.s_axi_bvalid = bvalid_q;
    assign bus.s_axi_bresp  = bresp_q;
    assign bus.s_axi_rvalid = rvalid_q;
    assign bus.s_axi_rdata  = rdata_q;
    assign bus.s_axi_rresp  = rresp_q;
    assign bus.s_axi_rlast  = rlast_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_instr    = mem_instr_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wstrb    = mem_wstrb_q;

    assign unused_sigs = ^{bus.s_axi_awlock, bus.s_axi_awcache, bus.s_axi_awqos, bus.s_axi_awprot[1:0],
                           bus.s_axi_arlock, bus.s_axi_arcache, bus.s_axi_arqos, bus.s_axi_arprot[1:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a latency-configurable memory target model.
module tb_axi_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    axi_mem_responder_if bus();

    axi_mem_responder #(.ADDR_BASE(32'h0), .MAX_LEN(255)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory target: logs every request, answers mem_lat cycles later.
    int          mem_lat = 1;
    bit          use_fixed = 1'b1;
    logic [31:0] rd_fixed = 32'h0;
    int          mv_count = 0;
    int          cnt = 0;
    logic [31:0] rd_word = 32'h0;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_wdata [0:63];
    logic [3:0]  log_wstrb [0:63];
    logic        log_instr [0:63];

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd_word;
                end
            end
            if (bus.mem_valid) begin
                log_addr[mv_count[5:0]]  = bus.mem_addr;
                log_wdata[mv_count[5:0]] = bus.mem_wdata;
                log_wstrb[mv_count[5:0]] = bus.mem_wstrb;
                log_instr[mv_count[5:0]] = bus.mem_instr;
                mv_count++;
                rd_word = use_fixed ? rd_fixed : {16'hCAFE, bus.mem_addr[15:0]};
                cnt = mem_lat;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [2:0] p);
        bit done = 1'b0;
        bus.s_axi_araddr = a; bus.s_axi_arlen = l; bus.s_axi_arsize = s;
        bus.s_axi_arburst = b; bus.s_axi_arprot = p; bus.s_axi_arvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.s_axi_arready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_axi_arvalid = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL ar_handshake: got no arready, required arready=1"); end
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [2:0] p);
        bit done = 1'b0;
        bus.s_axi_awaddr = a; bus.s_axi_awlen = l; bus.s_axi_awsize = s;
        bus.s_axi_awburst = b; bus.s_axi_awprot = p; bus.s_axi_awvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.s_axi_awready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_axi_awvalid = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL aw_handshake: got no awready, required awready=1"); end
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] st, input logic last);
        bit done = 1'b0;
        bus.s_axi_wdata = d; bus.s_axi_wstrb = st; bus.s_axi_wlast = last; bus.s_axi_wvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.s_axi_wready) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_axi_wvalid = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL w_handshake: got no wready, required wready=1"); end
    endtask

    task automatic r_recv(output logic [31:0] d, output logic [1:0] r, output logic l);
        bit done = 1'b0;
        bus.s_axi_rready = 1'b1;
        d = 'x; r = 'x; l = 1'bx;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.s_axi_rvalid) begin
                done = 1'b1; d = bus.s_axi_rdata; r = bus.s_axi_rresp; l = bus.s_axi_rlast;
            end
            @(posedge clk); #1;
        end
        bus.s_axi_rready = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL r_handshake: got no rvalid, required rvalid=1"); end
    endtask

    task automatic b_recv(output logic [1:0] r);
        bit done = 1'b0;
        bus.s_axi_bready = 1'b1;
        r = 'x;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.s_axi_bvalid) begin done = 1'b1; r = bus.s_axi_bresp; end
            @(posedge clk); #1;
        end
        bus.s_axi_bready = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL b_handshake: got no bvalid, required bvalid=1"); end
    endtask

    task automatic test_reset();
        bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0; bus.s_axi_awburst = '0;
        bus.s_axi_awlock = 1'b0; bus.s_axi_awcache = '0; bus.s_axi_awprot = '0; bus.s_axi_awqos = '0;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
        bus.s_axi_arlock = 1'b0; bus.s_axi_arcache = '0; bus.s_axi_arprot = '0; bus.s_axi_arqos = '0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid,
             bus.s_axi_rvalid, bus.s_axi_rlast, bus.mem_valid, bus.mem_instr} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 00000000", {bus.s_axi_awready, bus.s_axi_arready,
                     bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid, bus.s_axi_rlast, bus.mem_valid, bus.mem_instr});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0) begin
            failures++; $display("FAIL reset_mem: got %h, required 0", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
        end
        checks++;
        if ({bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_bresp} !== 36'h0) begin
            failures++; $display("FAIL reset_resp: got %h, required 0", {bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_bresp});
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready} !== 2'b11) begin
            failures++; $display("FAIL reset_idle_ready: got %b, required 11", {bus.s_axi_awready, bus.s_axi_arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        logic [31:0] d; logic [1:0] r; logic l; int m0;
        use_fixed = 1'b1; rd_fixed = 32'hDEADBEEF; mem_lat = 2; m0 = mv_count;
        ar_send(32'h100, 8'd0, 3'd2, 2'b01, 3'b100);
        r_recv(d, r, l);
        checks++;
        if (mv_count - m0 !== 1) begin failures++; $display("FAIL rd1_pulses: got %0d, required 1", mv_count - m0); end
        checks++;
        if (log_addr[m0[5:0]] !== 32'h100) begin failures++; $display("FAIL rd1_addr: got %h, required 00000100", log_addr[m0[5:0]]); end
        checks++;
        if ({log_instr[m0[5:0]], log_wstrb[m0[5:0]]} !== 5'b10000) begin
            failures++; $display("FAIL rd1_instr_wstrb: got %b, required 10000", {log_instr[m0[5:0]], log_wstrb[m0[5:0]]});
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL rd1_rdata: got %h, required deadbeef", d); end
        checks++;
        if ({r, l} !== 3'b001) begin failures++; $display("FAIL rd1_resp_last: got %b, required 001", {r, l}); end
    endtask

    task automatic test_write();
        logic [1:0] r; int m0; int held; bit seen;
        mem_lat = 1; m0 = mv_count; held = 0; seen = 1'b0;
        aw_send(32'h200, 8'd0, 3'd2, 2'b01, 3'b000);
        w_send(32'h12345678, 4'b0011, 1'b1);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.s_axi_bvalid;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL wr1_bvalid: got 0, required 1"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.s_axi_bvalid) held++;
        end
        checks++;
        if (held !== 5) begin failures++; $display("FAIL wr1_bvalid_hold: got %0d cycles, required 5", held); end
        @(posedge clk); #1;
        b_recv(r);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL wr1_bresp: got %b, required 00", r); end
        @(negedge clk);
        checks++;
        if (bus.s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL wr1_bvalid_drop: got 1, required 0"); end
        checks++;
        if (mv_count - m0 !== 1) begin failures++; $display("FAIL wr1_pulses: got %0d, required 1", mv_count - m0); end
        checks++;
        if ({log_addr[m0[5:0]], log_wdata[m0[5:0]], log_wstrb[m0[5:0]]} !== {32'h200, 32'h12345678, 4'b0011}) begin
            failures++;
            $display("FAIL wr1_mem: got %h %h %b, required 00000200 12345678 0011",
                     log_addr[m0[5:0]], log_wdata[m0[5:0]], log_wstrb[m0[5:0]]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst_read();
        logic [31:0] d, exp_d; logic [1:0] r, exp_r; logic l; int m0, exp_mv; bit seen, stable;
        use_fixed = 1'b0; mem_lat = 1; m0 = mv_count;
        ar_send(32'h1000, 8'd3, 3'd2, 2'b01, 3'b000);
        for (int b = 0; b < 4; b++) begin
`ifdef AXI_BURST_EN
            exp_d = 32'hCAFE1000 + 32'(b * 4); exp_r = 2'b00;
`else
            exp_d = 32'h0; exp_r = 2'b10;
`endif
            seen = 1'b0; d = 'x; r = 'x; l = 1'bx;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (bus.s_axi_rvalid) begin
                    seen = 1'b1; d = bus.s_axi_rdata; r = bus.s_axi_rresp; l = bus.s_axi_rlast;
                end
            end
            checks++;
            if (!seen) begin failures++; $display("FAIL burst_rvalid beat %0d: got 0, required 1", b); end
            stable = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                if ({bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast} !== {1'b1, d, r, l}) stable = 1'b0;
            end
            checks++;
            if (!stable) begin failures++; $display("FAIL burst_stall beat %0d: got changed rdata %h, required %h", b, bus.s_axi_rdata, d); end
            bus.s_axi_rready = 1'b1;
            @(posedge clk); #1;
            bus.s_axi_rready = 1'b0;
            checks++;
            if ({d, r, l} !== {exp_d, exp_r, (b == 3)}) begin
                failures++; $display("FAIL burst_beat %0d: got %h/%b/%b, required %h/%b/%b", b, d, r, l, exp_d, exp_r, b == 3);
            end
        end
`ifdef AXI_BURST_EN
        exp_mv = 4;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (log_addr[6'(m0 + b)] !== 32'h1000 + 32'(b * 4)) begin
                failures++; $display("FAIL burst_addr %0d: got %h, required %h", b, log_addr[6'(m0 + b)], 32'h1000 + 32'(b * 4));
            end
        end
`else
        exp_mv = 0;
`endif
        checks++;
        if (mv_count - m0 !== exp_mv) begin failures++; $display("FAIL burst_pulses: got %0d, required %0d", mv_count - m0, exp_mv); end
    endtask

    task automatic test_arbitration();
        logic [31:0] d; logic [1:0] r; logic l; int m0; bit seen; logic [1:0] rdy;
        use_fixed = 1'b1; rd_fixed = 32'h0BADF00D; mem_lat = 1; m0 = mv_count;
        bus.s_axi_awaddr = 32'h300; bus.s_axi_awlen = 8'd0; bus.s_axi_awsize = 3'd2; bus.s_axi_awburst = 2'b01;
        bus.s_axi_awprot = 3'b000;
        bus.s_axi_araddr = 32'h400; bus.s_axi_arlen = 8'd0; bus.s_axi_arsize = 3'd2; bus.s_axi_arburst = 2'b01;
        bus.s_axi_arprot = 3'b000;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        seen = 1'b0; rdy = 2'b00;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            rdy = {bus.s_axi_awready, bus.s_axi_arready};
            seen = |rdy;
        end
        checks++;
        if (rdy !== 2'b10) begin failures++; $display("FAIL arb_first: got aw/ar ready %b, required 10", rdy); end
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
        w_send(32'h55AA55AA, 4'hF, 1'b1);
        b_recv(r);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL arb_wr_bresp: got %b, required 00", r); end
        bus.s_axi_awaddr = 32'h500; bus.s_axi_awvalid = 1'b1;
        seen = 1'b0; rdy = 2'b00;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            rdy = {bus.s_axi_awready, bus.s_axi_arready};
            seen = |rdy;
        end
        checks++;
        if (rdy !== 2'b01) begin failures++; $display("FAIL arb_second: got aw/ar ready %b, required 01", rdy); end
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        r_recv(d, r, l);
        checks++;
        if ({d, r, l} !== {32'h0BADF00D, 2'b00, 1'b1}) begin
            failures++; $display("FAIL arb_rd: got %h/%b/%b, required 0badf00d/00/1", d, r, l);
        end
        aw_send(32'h500, 8'd0, 3'd2, 2'b01, 3'b000);
        w_send(32'hA1B2C3D4, 4'b1100, 1'b1);
        b_recv(r);
        checks++;
        if ({log_addr[m0[5:0]], log_addr[6'(m0 + 1)], log_addr[6'(m0 + 2)], log_wdata[6'(m0 + 2)]} !==
            {32'h300, 32'h400, 32'h500, 32'hA1B2C3D4}) begin
            failures++; $display("FAIL arb_order: got %h %h %h %h, required 00000300 00000400 00000500 a1b2c3d4",
                                 log_addr[m0[5:0]], log_addr[6'(m0 + 1)], log_addr[6'(m0 + 2)], log_wdata[6'(m0 + 2)]);
        end
    endtask

    task automatic test_err_read();
        logic [31:0] d; logic [1:0] r; logic l; int m0;
        m0 = mv_count;
        ar_send(32'h40, 8'd1, 3'd2, 2'b11, 3'b000);
        r_recv(d, r, l);
        checks++;
        if ({d, r, l} !== {32'h0, 2'b10, 1'b0}) begin failures++; $display("FAIL err_rd_beat0: got %h/%b/%b, required 0/10/0", d, r, l); end
        r_recv(d, r, l);
        checks++;
        if ({d, r, l} !== {32'h0, 2'b10, 1'b1}) begin failures++; $display("FAIL err_rd_beat1: got %h/%b/%b, required 0/10/1", d, r, l); end
        checks++;
        if (mv_count - m0 !== 0) begin failures++; $display("FAIL err_rd_pulses: got %0d, required 0", mv_count - m0); end
    endtask

    task automatic test_err_write();
        logic [1:0] r; int m0;
        mem_lat = 1; m0 = mv_count;
        aw_send(32'h80, 8'd0, 3'd3, 2'b01, 3'b000);
        w_send(32'hFFFF0000, 4'hF, 1'b1);
        b_recv(r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL err_size_bresp: got %b, required 10", r); end
        checks++;
        if (mv_count - m0 !== 0) begin failures++; $display("FAIL err_size_pulses: got %0d, required 0", mv_count - m0); end
        aw_send(32'h84, 8'd0, 3'd2, 2'b01, 3'b000);
        w_send(32'hA5A5A5A5, 4'b0000, 1'b0);
        b_recv(r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL wlast_bresp: got %b, required 10", r); end
        checks++;
        if ({mv_count - m0, log_wstrb[m0[5:0]], log_addr[m0[5:0]]} !== {32'd1, 4'b0000, 32'h84}) begin
            failures++; $display("FAIL wstrb0_req: got %0d pulses wstrb %b addr %h, required 1 0000 00000084",
                                 mv_count - m0, log_wstrb[m0[5:0]], log_addr[m0[5:0]]);
        end
    endtask

    task automatic test_reset_midburst();
        logic [1:0] r; int m0; bit seen;
        mem_lat = 2;
        aw_send(32'h600, 8'd0, 3'd2, 2'b01, 3'b000);
        w_send(32'h11112222, 4'hF, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_ready;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstmid_ready: got no mem_ready, required 1"); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_rvalid,
             bus.mem_valid, bus.s_axi_bresp, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 76'h0) begin
            failures++; $display("FAIL rstmid_outputs: got bvalid=%b wready=%b mem_addr=%h mem_wdata=%h, required all 0",
                                 bus.s_axi_bvalid, bus.s_axi_wready, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_bvalid} !== 3'b110) begin
            failures++; $display("FAIL rstmid_idle: got aw/ar/bvalid %b, required 110",
                                 {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_bvalid});
        end
        @(posedge clk); #1;
        mem_lat = 1; m0 = mv_count;
        aw_send(32'h700, 8'd0, 3'd2, 2'b01, 3'b000);
        w_send(32'h33334444, 4'hF, 1'b1);
        b_recv(r);
        checks++;
        if ({r, log_addr[m0[5:0]], log_wdata[m0[5:0]]} !== {2'b00, 32'h700, 32'h33334444}) begin
            failures++; $display("FAIL rstmid_next_write: got %b %h %h, required 00 00000700 33334444",
                                 r, log_addr[m0[5:0]], log_wdata[m0[5:0]]);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_burst_read();
        test_arbitration();
        test_err_read();
        test_err_write();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
